// File: rtl/imem_loader_pkg.sv
// Shared constants and FSM encoding for the instruction-memory loader.
package imem_loader_pkg;

   localparam int IMEM_ADDR_W    = 10;
   localparam int IMEM_DEPTH     = 1 << IMEM_ADDR_W;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_WRITE,
      S_DONE,
      S_CHECK
   } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input (valid/ready) plus instruction memory write port.
// master = loader side, slave = byte source / memory side.
interface imem_loader_if import imem_loader_pkg::*; #(
   parameter int ADDR_W = IMEM_ADDR_W
);
   logic              s_valid;
   logic [7:0]        s_data;
   logic              s_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   modport master (
      input  s_valid, s_data,
      output s_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output s_valid, s_data,
      input  s_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_byte_packer.sv
// Packs accepted bytes little-endian into a 32-bit word; word_full flags the 4th byte in its accept cycle.
// Assembly register updates on the accepting edge; no backpressure of its own.
module imem_byte_packer import imem_loader_pkg::*; (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  data,
   output logic [31:0] word,
   output logic        word_full
);

   logic [1:0] idx;

   assign word_full = accept && (idx == 2'(BYTES_PER_WORD - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx  <= '0;
         word <= '0;
      end else if (clear) begin
         idx  <= '0;
         word <= '0;
      end else if (accept) begin
         word[{idx, 3'b000} +: 8] <= data;
         idx                      <= idx + 2'd1;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory, one word write per 4 bytes (>=5 cycles/word), core held meanwhile.
// s_ready drops during the write bubble; IMEM_LOADER_CHECKSUM_EN adds an XOR trailer check after the last word.
module imem_loader import imem_loader_pkg::*; #(
   parameter int ADDR_W    = IMEM_ADDR_W,
   parameter int BASE_ADDR = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_start,
   input  logic [ADDR_W:0] load_words,
   imem_loader_if.master   bus,
   output logic            core_hold,
   output logic            busy,
   output logic            done,
   output logic            err
);

   localparam int DEPTH = 1 << ADDR_W;

   state_t          state, state_nxt;
   logic [ADDR_W:0] remaining;
   logic [31:0]     word;
   logic            accept, word_full, last_word, len_ok, start, active_nxt;

   assign bus.s_ready = (state == S_RECV) || (state == S_CHECK);
   assign accept      = bus.s_valid && bus.s_ready;
   assign last_word   = (remaining == (ADDR_W + 1)'(1));
   assign start       = load_start && ((state == S_IDLE) || (state == S_DONE));
   // Also rejects loads that would run past the top of memory for a non-zero base.
   assign len_ok      = (load_words != '0) && ((int'(load_words) + BASE_ADDR) <= DEPTH);
   assign active_nxt  = (state_nxt != S_IDLE) && (state_nxt != S_DONE);

   imem_byte_packer u_packer (
      .clk       (clk),
      .rst       (rst),
      .clear     (start && len_ok),
      .accept    (accept),
      .data      (bus.s_data),
      .word      (word),
      .word_full (word_full)
   );

   assign bus.mem_wdata = word;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (start && len_ok) state_nxt = S_RECV;
         S_RECV:         if (word_full) state_nxt = S_WRITE;
         S_WRITE: begin
            if (!last_word) state_nxt = S_RECV;
`ifdef IMEM_LOADER_CHECKSUM_EN
            else            state_nxt = S_CHECK;
`else
            else            state_nxt = S_DONE;
`endif
         end
         S_CHECK:        if (word_full) state_nxt = S_DONE;
         default:        state_nxt = S_IDLE;
      endcase
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0] csum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csum <= '0;
      end else if (start && len_ok) begin
         csum <= '0;
      end else if (state == S_WRITE) begin
         csum <= csum ^ word;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.mem_we   <= 1'b0;
         bus.mem_addr <= ADDR_W'(BASE_ADDR);
         remaining    <= '0;
         busy         <= 1'b0;
         core_hold    <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
      end else begin
         bus.mem_we <= (state_nxt == S_WRITE);
         busy       <= active_nxt;
         core_hold  <= active_nxt;
         if (start) begin
            done <= 1'b0;
            if (len_ok) begin
               err          <= 1'b0;
               remaining    <= load_words;
               bus.mem_addr <= ADDR_W'(BASE_ADDR);
            end else begin
               err <= 1'b1;
            end
         end
         if (state == S_WRITE) begin
            if (!last_word) begin
               bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
               remaining    <= remaining - (ADDR_W + 1)'(1);
            end
`ifndef IMEM_LOADER_CHECKSUM_EN
            else begin
               done <= 1'b1;
            end
`endif
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         // Trailer's last byte is still on s_data in its accept cycle.
         if ((state == S_CHECK) && word_full) begin
            done <= 1'b1;
            err  <= ({bus.s_data, word[23:0]} != csum);
         end
`endif
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: expected writes queued at stimulus time, popped by a write monitor.
module tb_imem_loader;
   import imem_loader_pkg::*;

   localparam int AW = IMEM_ADDR_W;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load_start = 1'b0;
   logic [AW:0]   load_words = '0;
   logic          core_hold, busy, done, err;
   int            checks = 0;
   int            errors = 0;
   int            wr_cnt = 0;
   bit            toggle_mode = 1'b0;
   wr_t           exp_q[$];
   logic [31:0]   stim_words[$];

   imem_loader_if #(.ADDR_W(AW)) bus ();

   imem_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start),
      .load_words (load_words),
      .bus        (bus),
      .core_hold  (core_hold),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Write monitor: every mem_we pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      wr_t e;
      if (!rst && bus.mem_we) begin
         wr_cnt++;
         chk("s_ready_in_write", 32'(bus.s_ready), 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write", bus.mem_addr, bus.mem_wdata);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
            chk("wr_data", bus.mem_wdata, e.data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit acc = 1'b0;
      int guard = 0;
      if (toggle_mode) begin
         bus.s_valid = 1'b0;
         tick();
      end else begin
         while ($urandom_range(0, 3) == 0) begin
            bus.s_valid = 1'b0;
            tick();
         end
      end
      bus.s_valid = 1'b1;
      bus.s_data  = b;
      while (!acc) begin
         @(negedge clk);
         acc = bus.s_ready;
         @(posedge clk);
         #1;
         guard++;
         if (!acc && guard > 50) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: got no s_ready in %0d cycles expected acceptance", guard);
            break;
         end
      end
      bus.s_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 0; k < BYTES_PER_WORD; k++)
         send_byte(8'((w >> (8 * k)) & 32'hFF));
   endtask

   task automatic start_load(input int n);
      load_words = (AW + 1)'(n);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   // Loads stim_words[0..n-1]; optionally pulses load_start mid-word-0 (must be ignored).
   task automatic run_load(input int n, input bit good_trailer, input bit mid_pulse);
      logic [31:0] x = '0;
      logic [31:0] w;
      int          base_wr;
      bit          exp_err = 1'b0;
      base_wr = wr_cnt;
      start_load(n);
      @(negedge clk);
      chk("s_ready_after_start", 32'(bus.s_ready), 32'd1);
      chk("busy_loading", 32'(busy), 32'd1);
      chk("core_hold_loading", 32'(core_hold), 32'd1);
      chk("done_cleared", 32'(done), 32'd0);
      tick();
      for (int i = 0; i < n; i++) begin
         w = stim_words[i];
         exp_q.push_back({AW'(i), w});
         x = x ^ w;
         for (int k = 0; k < BYTES_PER_WORD; k++) begin
            send_byte(8'((w >> (8 * k)) & 32'hFF));
            if (mid_pulse && i == 0 && k == 1) begin
               load_words = (AW + 1)'(1);
               load_start = 1'b1;
               tick();
               load_start = 1'b0;
            end
         end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_word(good_trailer ? x : x + 32'd1);
      exp_err = !good_trailer;
`else
      exp_err = good_trailer & 1'b0;
`endif
      for (int c = 0; c < 20 && !done; c++) @(negedge clk);
      chk("done_after_load", 32'(done), 32'd1);
      chk("err_after_load", 32'(err), 32'(exp_err));
      chk("core_hold_after", 32'(core_hold), 32'd0);
      chk("busy_after", 32'(busy), 32'd0);
      chk("s_ready_in_done", 32'(bus.s_ready), 32'd0);
      chk("write_count", 32'(wr_cnt - base_wr), 32'(n));
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      tick();
   endtask

   task automatic bad_len(input int n);
      int base_wr;
      base_wr = wr_cnt;
      start_load(n);
      repeat (3) begin
         @(negedge clk);
         chk("bad_len_err", 32'(err), 32'd1);
         chk("bad_len_done", 32'(done), 32'd0);
         chk("bad_len_s_ready", 32'(bus.s_ready), 32'd0);
         chk("bad_len_busy", 32'(busy), 32'd0);
      end
      chk("bad_len_writes", 32'(wr_cnt - base_wr), 32'd0);
      tick();
   endtask

   task automatic rand_words(input int n);
      logic [7:0]  b;
      logic [31:0] w;
      stim_words.delete();
      for (int i = 0; i < n; i++) begin
         w = '0;
         for (int k = 0; k < BYTES_PER_WORD; k++) begin
            b = 8'($urandom_range(0, 255));
            w = w + (32'(b) << (8 * k));
         end
         stim_words.push_back(w);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish expected completion before timeout");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0]  dir_bytes[8];
      logic [31:0] w;
      int          base_wr;

      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      #12;
      chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
      chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_core_hold", 32'(core_hold), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // Directed two-word load; words assembled from the byte list LSB first.
      dir_bytes = '{8'h03, 8'hA3, 8'hC4, 8'hFF, 8'h11, 8'h11, 8'h11, 8'h11};
      stim_words.delete();
      for (int i = 0; i < 2; i++) begin
         w = '0;
         for (int k = 0; k < 4; k++) w = w + (32'(dir_bytes[4 * i + k]) << (8 * k));
         stim_words.push_back(w);
      end
      run_load(2, 1'b1, 1'b0);

      toggle_mode = 1'b1;
      rand_words(1);
      run_load(1, 1'b1, 1'b0);
      toggle_mode = 1'b0;

      bad_len(0);
      bad_len(1025);

      rand_words(3);
      run_load(3, 1'b1, 1'b1);

      for (int r = 0; r < 6; r++) begin
         rand_words($urandom_range(1, 5));
         run_load(stim_words.size(), 1'($urandom_range(0, 1)), 1'b0);
      end

      stim_words.delete();
      stim_words.push_back(32'h11111111);
      stim_words.push_back(32'h22222222);
      run_load(2, 1'b1, 1'b0);
      run_load(2, 1'b0, 1'b0);

      // Reset after 6 bytes of a 3-word load: word 0 written, word 1 never.
      rand_words(3);
      base_wr = wr_cnt;
      start_load(3);
      exp_q.push_back({AW'(0), stim_words[0]});
      send_word(stim_words[0]);
      send_byte(8'(stim_words[1] & 32'hFF));
      send_byte(8'((stim_words[1] >> 8) & 32'hFF));
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_s_ready", 32'(bus.s_ready), 32'd0);
      chk("midrst_mem_we", 32'(bus.mem_we), 32'd0);
      chk("midrst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("midrst_mem_wdata", bus.mem_wdata, 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_core_hold", 32'(core_hold), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_err", 32'(err), 32'd0);
      chk("midrst_writes", 32'(wr_cnt - base_wr), 32'd1);
      chk("midrst_queue", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      tick();
      rst = 1'b0;
      tick();

      rand_words(2);
      run_load(2, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Writer side of the instruction memory: accepts a byte stream with a valid/ready handshake, packs bytes little-endian into 32-bit instructions, and drives the instruction memory write port at consecutive word addresses. Sits between the host/debug byte source and the instruction memory. Holds the core in reset while a program is loaded, so fetch reads never race an in-progress write.

## Interface
- ADDR_W, 10, word-address width (memory depth 2**ADDR_W = 1024 words)
- BASE_ADDR, 0, first word address written by a load
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  reset: asynchronous, active-high
- load_start  in  1  one-cycle pulse; starts a load, sampled only in IDLE/DONE
- load_words  in  ADDR_W+1  number of instruction words to load, sampled with load_start; legal range 1..2**ADDR_W
- s_valid  in  1  byte available
- s_data  in  8  byte, least-significant byte of each word first
- s_ready  out  1  loader accepts s_data this cycle
- mem_we  out  1  instruction memory write enable, one cycle per word
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  instruction word
- core_hold  out  1  high while loading; drives the core/fetch reset so instruction memory reads return 0
- busy  out  1  load in progress
- done  out  1  last load completed; held until next load_start or rst
- err  out  1  last load rejected or failed; held until next load_start or rst

## Operation
- States: IDLE, RECV, WRITE, DONE (plus CHECK when the checksum is compiled in).
- IDLE/DONE + load_start: load_words of 0 or above 2**ADDR_W sets err, clears done, and stays in the current state. Otherwise it latches the count, sets the address to BASE_ADDR, clears byte index, done and err, then enters RECV.
- RECV: s_ready=1; a byte is accepted when s_valid && s_ready. Byte k (k=0..3) goes to wdata[8k+7:8k]. Accepting byte 3 enters WRITE.
- WRITE: s_ready=0, mem_we=1, mem_addr=current address, mem_wdata=assembled word. Next state: if this was the last word, DONE (or CHECK); else RECV with address+1 and remaining count−1.
- DONE: done=1, core_hold=0.
- load_start during RECV/WRITE/CHECK is ignored.
- Address never wraps: the length check guarantees BASE_ADDR+load_words−1 ≤ 2**ADDR_W−1 when BASE_ADDR=0. A non-zero BASE_ADDR additionally requires BASE_ADDR+load_words ≤ 2**ADDR_W, or err is set.
- busy = core_hold = (state ≠ IDLE && state ≠ DONE).

## Timing
- Reset values: state IDLE; s_ready, mem_we, busy, core_hold, done, err all 0; mem_addr=BASE_ADDR; mem_wdata=0.
- rst mid-load: immediate return to IDLE. Words already written stay in memory; done=0 and err=0.
- load_start to s_ready high: 1 cycle.
- mem_we asserts the cycle after the 4th byte is accepted; minimum 5 cycles per word (4 bytes + 1 write bubble).
- done rises the cycle after the last WRITE (or after CHECK); core_hold falls in that same cycle.
- Outputs are registered, except s_ready, which is decoded from state.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined: after the last WRITE, enter CHECK. CHECK receives 4 more bytes (a little-endian trailer word) with the same handshake, and compares the trailer to the XOR of all written words. Mismatch sets err and done together; match sets done only. Nothing is written in CHECK.
- Undefined: no CHECK state; the last WRITE goes straight to DONE; err comes only from length rejection.

## Structure
- Package imem_loader_pkg holds: state enum, IMEM_ADDR_W=10, IMEM_DEPTH=1024, BYTES_PER_WORD=4.
- Sub-module imem_byte_packer: 2-bit byte index and 32-bit little-endian assembly register, with clear and accept inputs and a word_full output. It is reused by CHECK for the trailer.

## Test plan
- Reset, then load_start with load_words=2 and bytes 03 A3 C4 FF 11 11 11 11: writes mem[0]=32'hFFC4A303 and mem[1]=32'h11111111, two mem_we pulses, then done=1 and core_hold=0.
- s_valid toggling every other cycle during a 1-word load: exactly one write, with correct byte order. s_ready stays low in the WRITE cycle.
- load_words=0, and separately load_words=1025: err=1, no s_ready, no mem_we, state unchanged.
- rst asserted after 6 bytes of a 3-word load: mem[0] was written, mem[1] is not; outputs return to their reset values asynchronously.
- load_start pulsed during RECV: ignored; the load finishes with its original count.
- With IMEM_LOADER_CHECKSUM_EN and words 0x11111111, 0x22222222: a trailer of 0x33333333 gives done=1, err=0; a trailer of 0x33333334 gives done=1, err=1.
